// File: rtl/prio_arbiter_pkg.sv
// prio_arbiter_pkg: shared types and helpers for the priority arbiter.
//   state_e  : arbiter FSM states (IDLE, HOLD)
//   calc_iw  : index width derived from the number of request lines
package prio_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic int calc_iw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// prio_pick: purely combinational winner search over a request vector.
// Ports:
//   vector [N]  : candidate request bits
//   start  [IW] : search start position (used only in round-robin mode)
//   mode        : 0 = highest set index wins, 1 = ascending from start, wrapping
//   found       : at least one bit of vector is set
//   idx    [IW] : winning index (0 when nothing found)
//   onehot [N]  : one-hot of idx, zero when nothing found
module prio_pick
  import prio_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = calc_iw(N)
) (
  input  logic [N-1:0]  vector,
  input  logic [IW-1:0] start,
  input  logic          mode,
  output logic          found,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  logic [N-1:0] rot;
  int           sel;

  always_comb begin
    found = |vector;
    sel   = 0;
    // Rotate so the start position lands on bit 0; the lowest set bit of
    // rot is then the first hit of an ascending, wrapping search.
    rot   = N'({vector, vector} >> start);
    if (mode) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (rot[k]) sel = (int'(start) + k) % N;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (vector[i]) sel = i;
      end
    end
    idx    = IW'(sel);
    onehot = found ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/prio_arbiter.sv
// prio_arbiter: request coalescing arbiter with registered grant output.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req [N]     : request pulses, OR-ed into the sticky pending register
//   out_ready   : consumer accepts the presented grant
//   out_valid   : a grant is presented
//   out_idx     : binary index of the granted line (holds after the last grant)
//   out_onehot  : one-hot grant, zero while out_valid is low
//   pending [N] : sticky request register
// Build option: define PRIO_ARBITER_RR_EN for round-robin arbitration;
// otherwise fixed priority (highest index wins) and no pointer register.
//
// state | meaning
// IDLE  | no grant presented, waiting for any request
// HOLD  | grant presented, held until out_ready
module prio_arbiter
  import prio_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = calc_iw(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [IW-1:0] out_idx,
  output logic [N-1:0]  out_onehot,
  output logic [N-1:0]  pending
);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  onehot_q, onehot_d;
  logic [N-1:0]  pending_q, pending_d;

  logic [N-1:0]  cand;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [N-1:0]  pick_onehot;
  logic [IW-1:0] start;
  logic          mode;
  logic          issue;

  // Same-edge requests take part in arbitration, giving one-cycle latency.
  assign cand  = pending_q | req;
  assign issue = pick_found && ((state_q == IDLE) || out_ready);

`ifdef PRIO_ARBITER_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;

  assign start = ptr_q;
  assign mode  = 1'b1;

  always_comb begin
    ptr_d = ptr_q;
    if (issue) ptr_d = IW'((int'(pick_idx) + 1) % N);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  assign start = '0;
  assign mode  = 1'b0;
`endif

  prio_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .vector (cand),
    .start  (start),
    .mode   (mode),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    onehot_d  = onehot_q;
    pending_d = cand;
    if (issue) begin
      state_d   = HOLD;
      idx_d     = pick_idx;
      onehot_d  = pick_onehot;
      // A same-edge request on the winning line is absorbed by this grant.
      pending_d = cand & ~pick_onehot;
    end else if ((state_q == HOLD) && out_ready) begin
      state_d  = IDLE;
      onehot_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      onehot_q  <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      onehot_q  <= onehot_d;
      pending_q <= pending_d;
    end
  end

  assign out_valid  = (state_q == HOLD);
  assign out_idx    = idx_q;
  assign out_onehot = onehot_q;
  assign pending    = pending_q;

endmodule

// File: doc/prio_arbiter.md
PRIO_ARBITER -- requirements
Module: prio_arbiter

Interface
REQ-001 Parameter N, default 4: number of request lines, legal range 2..32.
REQ-002 Parameter IW, default $clog2(N): index width, derived, never overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  N  request lines; bit i high in a cycle = one request event on line i.
REQ-006 out_ready  input  1  consumer accepts the current grant.
REQ-007 out_valid  output  1  grant is presented.
REQ-008 out_idx  output  IW  binary index of the granted line.
REQ-009 out_onehot  output  N  one-hot form of out_idx; zero when out_valid=0.
REQ-010 pending  output  N  sticky request register, for observation.

Function
REQ-011 Every sampled req bit SHALL be OR-ed into pending; requests are never lost, only coalesced per line.
REQ-012 FSM states IDLE and HOLD SHALL be used; IDLE -> HOLD when (pending|req)!=0 at an edge.
REQ-013 On grant issue, the winner SHALL come from (pending|req), be registered into out_idx/out_onehot, and out_valid SHALL go high; latency is one cycle from req to out_valid.
REQ-014 On grant issue, pending SHALL become (pending|req) & ~grant_onehot; a req on the winning line at the same edge is consumed by that grant.
REQ-015 In HOLD with out_ready=0, out_valid/out_idx/out_onehot SHALL remain stable; pending keeps accumulating req, including the held line.
REQ-016 On handshake (out_valid & out_ready) with (pending|req)!=0, the next grant SHALL be issued at the same edge and out_valid SHALL stay high (back-to-back, one grant per cycle).
REQ-017 On handshake with (pending|req)==0, state -> IDLE, out_valid=0, out_onehot=0, out_idx holds last value.
REQ-018 Fixed mode: the highest set index SHALL win.
REQ-019 out_onehot SHALL equal 1<<out_idx whenever out_valid=1.

Reset
REQ-020 rst_n low SHALL immediately force state=IDLE, out_valid=0, out_idx=0, out_onehot=0, pending=0, rr pointer=0, regardless of operation in progress.
REQ-021 req SHALL be ignored while rst_n is low; the first grant is possible one edge after release.

Configuration
REQ-022 Macro PRIO_ARBITER_RR_EN defined: round-robin arbitration; search ascends from pointer ptr (wrapping mod N), first set bit wins, ptr <= (winner+1) mod N after each grant.
REQ-023 PRIO_ARBITER_RR_EN undefined: fixed priority per REQ-018; no pointer register is synthesised.

Structure
REQ-024 Package prio_arbiter_pkg SHALL hold the state enum typedef (IDLE, HOLD) and the IW derivation function.
REQ-025 Sub-module prio_pick SHALL be a combinational search: inputs vector[N], start[IW], mode; outputs found, idx, onehot.
REQ-026 prio_arbiter SHALL contain all registers; prio_pick SHALL contain none.

Verification (N=4)
REQ-027 Reset: assert rst_n=0 mid-stream with pending=1010, out_valid=1 -> all outputs and pending are 0 immediately; no grant after release while req=0.
REQ-028 Single: req=0010 for one cycle, out_ready=1 -> next cycle out_valid=1, out_idx=1, out_onehot=0010; following cycle out_valid=0.
REQ-029 Fixed priority: req=1011 for one cycle, out_ready=1 -> out_idx 3,1,0 on three consecutive cycles, then out_valid=0.
REQ-030 Backpressure: req=0100 then out_ready=0 for 5 cycles with req=1000 pulsed -> out_idx=2 stable, pending=1000; after out_ready=1 the next grant is out_idx=3.
REQ-031 Coalescing: req=0001 for 3 cycles while out_ready=0 holds grant 0 -> exactly one further grant of index 0 after release.
REQ-032 Round-robin (PRIO_ARBITER_RR_EN): req=1111 held, out_ready=1 -> out_idx sequence 0,1,2,3,0.
